// File: rtl/prio_sched_pkg.sv
// Shared types and bit-vector helpers for the priority request scheduler.
package prio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ostate_t;

  // Helpers work on vectors up to 64 bits; callers zero-extend and truncate.
  function automatic logic [5:0] onehot2bin(input logic [63:0] v);
    logic [5:0] r;
    r = '0;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 64; i++) begin
        if (i[b]) r[b] = r[b] | v[i];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {7'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/prio_sched_if.sv
// Request/grant bundle between event sources, the scheduler and the downstream server.
interface prio_sched_if #(
  parameter int DW = 32,
  parameter int AW = $clog2(DW),
  parameter int CW = $clog2(DW + 1)
);
  logic          flush;
  logic [DW-1:0] req_in;
  logic [DW-1:0] mask;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_onehot;
  logic [AW-1:0] out_index;
  logic [DW-1:0] pending;
  logic [CW-1:0] pend_cnt;
  logic          drop;

  modport master (
    output flush, req_in, mask, out_ready,
    input  out_valid, out_onehot, out_index, pending, pend_cnt, drop
  );

  modport slave (
    input  flush, req_in, mask, out_ready,
    output out_valid, out_onehot, out_index, pending, pend_cnt, drop
  );
endinterface

// File: rtl/prio_sched_bin2prio.sv
// Highest-index-wins priority selector: one-hot of the top set bit plus any-set flag.
module bin2prio #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] vec_i,
  output logic [DW-1:0] onehot_o,
  output logic          valid_o
);

  // Ascending scan so the last (highest) set bit overwrites earlier ones.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < DW; i++) begin
      if (vec_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

  assign valid_o = |vec_i;

endmodule

// File: rtl/prio_sched.sv
// Sticky request accumulator feeding a registered one-hot/index grant stage
// over a valid/ready handshake.
module prio_sched
  import prio_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = $clog2(DW),
  parameter int CW = $clog2(DW + 1)
) (
  input logic         clk,
  input logic         rst,
  prio_sched_if.slave bus
);

  logic [DW-1:0] cand;
  logic [DW-1:0] sel;
  logic          sel_vld;
  logic          load;
  logic [DW-1:0] pending_q, pending_d;
  logic          drop_q, drop_d;
  logic [DW-1:0] onehot_q;
  logic [AW-1:0] index_q;
  ostate_t       state_q;

  assign cand = pending_q & ~bus.mask;

  bin2prio #(.DW(DW)) u_sel (
    .vec_i    (cand),
    .onehot_o (sel),
    .valid_o  (sel_vld)
  );

  assign load = ((state_q == IDLE) || bus.out_ready) && sel_vld;

  // A bit leaves pending when it is loaded, and a same-cycle request re-arms it.
  assign pending_d = (pending_q & ~(load ? sel : '0)) | bus.req_in;
  assign drop_d    = |(bus.req_in & pending_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      drop_q    <= 1'b0;
      onehot_q  <= '0;
      index_q   <= '0;
      state_q   <= IDLE;
    end else if (bus.flush) begin
      pending_q <= '0;
      drop_q    <= 1'b0;
      onehot_q  <= '0;
      index_q   <= '0;
      state_q   <= IDLE;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q  <= HOLD;
            onehot_q <= sel;
            index_q  <= AW'(onehot2bin(64'(sel)));
          end
        end
        HOLD: begin
          if (load) begin
            onehot_q <= sel;
            index_q  <= AW'(onehot2bin(64'(sel)));
          end else if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_onehot = onehot_q;
  assign bus.out_index  = index_q;
  assign bus.pending    = pending_q;
  assign bus.pend_cnt   = CW'(popcount(64'(pending_q)));
  assign bus.drop       = drop_q;

endmodule

// File: tb/tb_prio_sched.sv
// Directed and randomized bench for prio_sched against a behavioural scheduler model.
module tb_prio_sched;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  prio_sched_if #(.DW(DW)) bus ();

  prio_sched #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [DW-1:0] m_pend;
  logic          m_vld;
  logic [DW-1:0] m_oh;
  int            m_idx;
  logic          m_drop;

  function automatic int highest(input logic [DW-1:0] v);
    for (int i = DW - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int ones(input logic [DW-1:0] v);
    int n = 0;
    for (int i = 0; i < DW; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_vld = 1'b0; m_oh = '0; m_idx = 0; m_drop = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   64'(bus.out_valid),  64'(m_vld));
    chk({tag, ".onehot"},  64'(bus.out_onehot), 64'(m_oh));
    chk({tag, ".index"},   64'(bus.out_index),  64'(m_idx));
    chk({tag, ".pending"}, 64'(bus.pending),    64'(m_pend));
    chk({tag, ".cnt"},     64'(bus.pend_cnt),   64'(ones(m_pend)));
    chk({tag, ".drop"},    64'(bus.drop),       64'(m_drop));
  endtask

  // One clock: predict from current inputs, advance, then compare just after the edge.
  task automatic step(input string tag);
    logic [DW-1:0] n_pend, c;
    logic          n_vld, n_drop;
    logic [DW-1:0] n_oh;
    int            n_idx, hi;
    if (bus.flush) begin
      n_pend = '0; n_vld = 1'b0; n_oh = '0; n_idx = 0; n_drop = 1'b0;
    end else begin
      n_pend = m_pend; n_vld = m_vld; n_oh = m_oh; n_idx = m_idx;
      c      = m_pend & ~bus.mask;
      hi     = highest(c);
      n_drop = (bus.req_in & m_pend) != '0;
      if ((!m_vld || bus.out_ready) && hi >= 0) begin
        n_pend[hi] = 1'b0;
        n_vld      = 1'b1;
        n_idx      = hi;
        n_oh       = '0;
        n_oh[hi]   = 1'b1;
      end else if (bus.out_ready) begin
        n_vld = 1'b0;
      end
      n_pend = n_pend | bus.req_in;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_vld = n_vld; m_oh = n_oh; m_idx = n_idx; m_drop = n_drop;
    check_all(tag);
  endtask

  task automatic drive(input logic [DW-1:0] req, input logic [DW-1:0] msk,
                       input logic rdy, input logic fl);
    bus.req_in = req; bus.mask = msk; bus.out_ready = rdy; bus.flush = fl;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid",   64'(bus.out_valid), 64'd0);
    chk("reset.pending", 64'(bus.pending),   64'd0);
    chk("reset.index",   64'(bus.out_index), 64'd0);
    chk("reset.drop",    64'(bus.drop),      64'd0);
    rst = 1'b0;

    // Quiet after reset
    for (int i = 0; i < 10; i++) step("idle");

    // Three requests in one pulse, served highest first
    drive(32'h8000_0011, '0, 1'b1, 1'b0);
    step("burst.req");
    drive('0, '0, 1'b1, 1'b0);
    step("burst.g31"); chk("burst.idx31", 64'(bus.out_index), 64'd31);
    step("burst.g4");  chk("burst.idx4",  64'(bus.out_index), 64'd4);
    step("burst.g0");  chk("burst.idx0",  64'(bus.out_index), 64'd0);
    step("burst.end"); chk("burst.empty", 64'(bus.out_valid), 64'd0);

    // Back-pressure holds the grant stable
    drive(32'h0000_0220, '0, 1'b0, 1'b0);
    step("bp.req");
    drive('0, '0, 1'b0, 1'b0);
    step("bp.load");
    for (int i = 0; i < 4; i++) begin
      step("bp.hold");
      chk("bp.idx9", 64'(bus.out_index), 64'd9);
      chk("bp.pend", 64'(bus.pending),   64'h20);
    end
    drive('0, '0, 1'b1, 1'b0);
    step("bp.next"); chk("bp.idx5", 64'(bus.out_index), 64'd5);
    step("bp.drain");

    // Masked line stays pending while a lower one is served
    drive(32'h0000_0208, 32'h0000_0200, 1'b1, 1'b0);
    step("mask.req");
    drive('0, 32'h0000_0200, 1'b1, 1'b0);
    step("mask.g3"); chk("mask.idx3", 64'(bus.out_index), 64'd3);
    drive('0, '0, 1'b1, 1'b0);
    step("mask.g9"); chk("mask.idx9", 64'(bus.out_index), 64'd9);
    step("mask.drain");

    // Drop on a re-request of a pending bit; no drop for an in-flight bit
    drive(32'h4, '1, 1'b1, 1'b0);
    step("drop.arm");
    drive(32'h4, '1, 1'b1, 1'b0);
    step("drop.hit");
    chk("drop.pulse", 64'(bus.drop), 64'd1);
    chk("drop.cnt",   64'(bus.pend_cnt), 64'd1);
    drive('0, '0, 1'b0, 1'b0);
    step("drop.load"); chk("drop.clear", 64'(bus.drop), 64'd0);
    drive(32'h4, '0, 1'b0, 1'b0);
    step("inflight.req"); chk("inflight.nodrop", 64'(bus.drop), 64'd0);
    drive('0, '0, 1'b1, 1'b0);
    step("inflight.regrant"); chk("inflight.idx2", 64'(bus.out_index), 64'd2);
    step("inflight.drain");

    // Flush beats a same-cycle request
    drive(32'hF0, '0, 1'b0, 1'b0);
    step("flush.fill");
    drive(32'hF, '0, 1'b0, 1'b1);
    step("flush.do");
    chk("flush.pend",  64'(bus.pending),   64'd0);
    chk("flush.valid", 64'(bus.out_valid), 64'd0);
    drive('0, '0, 1'b0, 1'b0);
    step("flush.after");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] r, m;
      r = ($urandom_range(0, 2) == 0) ? ($urandom & $urandom) : '0;
      m = ($urandom_range(0, 3) == 0) ? $urandom : '0;
      drive(r, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
      step("rand");
    end

    // Asynchronous reset while a grant is held
    drive(32'h0001_0000, '0, 1'b0, 1'b0);
    step("arst.req");
    drive(32'h3, '0, 1'b0, 1'b0);
    step("arst.hold");
    chk("arst.pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst.now");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive('0, '0, 1'b1, 1'b0);
    step("arst.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
